pp_pipeline_accel_line_buffer_pair_reader: RTL and testbench

- Read-side controller for the resize line buffer RAM (1 write / N read, 1-cycle registered read).
- Accepts column requests and drives the RAM read port (address1/ce1/q1) for columns x and x+1.
- Returns the horizontal neighbour pair needed by the bilinear datapath on a valid/ready output.
- Sits between the resize coordinate generator and the interpolation arithmetic; the write side of the RAM stays with the line fill logic.

---
 rtl/pp_pipeline_accel_line_buffer_pair_reader_if.sv | 30 +++
 rtl/pp_pipeline_accel_line_buffer_pair_reader.sv | 119 +++++++++++
 tb/tb_pp_pipeline_accel_line_buffer_pair_reader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pp_pipeline_accel_line_buffer_pair_reader_if.sv
// Port bundle for the line-buffer pair reader: request side, RAM read port and pair output.
// The slave view belongs to the reader; the master view belongs to its surroundings.
interface pp_pipeline_accel_line_buffer_pair_reader_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] cfg_width;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_col;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_ce;
  logic [DATA_W-1:0] ram_q;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_p0;
  logic [DATA_W-1:0] out_p1;
  logic              out_clamped;
  logic              busy;

  modport slave (
    input  cfg_width, req_valid, req_col, ram_q, out_ready,
    output req_ready, ram_address, ram_ce, out_valid, out_p0, out_p1, out_clamped, busy
  );

  modport master (
    output cfg_width, req_valid, req_col, ram_q, out_ready,
    input  req_ready, ram_address, ram_ce, out_valid, out_p0, out_p1, out_clamped, busy
  );
endinterface

// File: rtl/pp_pipeline_accel_line_buffer_pair_reader.sv
// Reads columns x and x+1 (clamped to the active line width) from the resize line buffer
// and presents them as a pixel pair for the bilinear datapath.
module pp_pipeline_accel_line_buffer_pair_reader #(
  parameter int DATA_W     = 24,
  parameter int ADDR_W     = 12,
  parameter int ADDR_RANGE = 3840
) (
  input logic clk,
  input logic reset,
  pp_pipeline_accel_line_buffer_pair_reader_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD0  = 2'd1;
  localparam logic [1:0] RD1  = 2'd2;
  localparam logic [1:0] LAND = 2'd3;

  localparam logic [ADDR_W:0] RANGE_L = (ADDR_W+1)'(ADDR_RANGE);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  // Last addressable column for a configured width; width 0 behaves as a 1-pixel line.
  function automatic logic [ADDR_W:0] eff_last(input logic [ADDR_W-1:0] width);
    logic [ADDR_W:0] w;
    if (width == '0)
      w = ONE_L;
    else if ({1'b0, width} > RANGE_L)
      w = RANGE_L;
    else
      w = {1'b0, width};
    return w - ONE_L;
  endfunction

  // Saturate a widened column index at the right edge of the line.
  function automatic logic [ADDR_W-1:0] sat_col(input logic [ADDR_W:0] col,
                                                input logic [ADDR_W:0] last);
    return (col >= last) ? last[ADDR_W-1:0] : col[ADDR_W-1:0];
  endfunction

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] c1_p0;
  logic              clamped_p0;
  logic [DATA_W-1:0] p0_hold_p1;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_p0_q;
  logic [DATA_W-1:0] out_p1_q;
  logic              out_clamped_q;

  logic [ADDR_W:0]   last_col;
  logic [ADDR_W:0]   col_x0;
  logic [ADDR_W:0]   col_x1;
  logic              accept;
  logic              load;

  always_comb begin
    last_col = eff_last(bus.cfg_width);
    col_x0   = {1'b0, bus.req_col};
    col_x1   = col_x0 + ONE_L;
    accept   = (state == IDLE) && bus.req_valid;
    load     = (state == LAND) && (!out_valid_q || bus.out_ready);
  end

  // Accept stage: clamped columns captured once, so later cfg_width changes do not matter.
  always_ff @(posedge clk) begin
    if (accept) begin
      c1_p0      <= sat_col(col_x1, last_col);
      clamped_p0 <= (col_x0 >= last_col);
    end
    // Read stage: ram_q carries the c0 word in the cycle after RD0.
    if (state == RD1)
      p0_hold_p1 <= bus.ram_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr_q        <= '0;
      out_valid_q   <= 1'b0;
      out_p0_q      <= '0;
      out_p1_q      <= '0;
      out_clamped_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state  <= RD0;
            addr_q <= sat_col(col_x0, last_col);
          end
        end
        RD0: begin
          state  <= RD1;
          addr_q <= c1_p0;
        end
        RD1:     state <= LAND;
        LAND:    if (load) state <= IDLE;
        default: state <= IDLE;
      endcase
      // Output stage: the RAM holds the c1 word in LAND because ce is low there.
      if (load) begin
        out_valid_q   <= 1'b1;
        out_p0_q      <= p0_hold_p1;
        out_p1_q      <= bus.ram_q;
        out_clamped_q <= clamped_p0;
      end else if (bus.out_ready) begin
        out_valid_q   <= 1'b0;
      end
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.ram_ce      = (state == RD0) || (state == RD1);
  assign bus.ram_address = addr_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_p0      = out_p0_q;
  assign bus.out_p1      = out_p1_q;
  assign bus.out_clamped = out_clamped_q;
  assign bus.busy        = (state != IDLE) || out_valid_q;

endmodule

// File: tb/tb_pp_pipeline_accel_line_buffer_pair_reader.sv
// Directed bench for the line-buffer pair reader with a registered-read RAM model
// preloaded with mem[i] = i * 0x010101.
module tb_pp_pipeline_accel_line_buffer_pair_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pp_pipeline_accel_line_buffer_pair_reader_if #(.DATA_W(24), .ADDR_W(12)) bus ();

  pp_pipeline_accel_line_buffer_pair_reader #(
    .DATA_W(24), .ADDR_W(12), .ADDR_RANGE(3840)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [23:0] mem [0:4095];
  logic [23:0] ram_q_r = '0;
  always @(posedge clk) if (bus.ram_ce) ram_q_r <= mem[bus.ram_address];
  assign bus.ram_q = ram_q_r;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [11:0] width;
    logic [11:0] col;
    logic [11:0] a0;
    logic [11:0] a1;
    logic [23:0] p0;
    logic [23:0] p1;
    logic        cl;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request at a negedge with the output slot free and checks the full 4-cycle flow.
  task automatic run_req(input string tag, input logic [11:0] width, input logic [11:0] col,
                         input logic [11:0] a0, input logic [11:0] a1,
                         input logic [23:0] p0, input logic [23:0] p1, input logic cl);
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_col   = col;
    bus.cfg_width = width;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.cfg_width = 12'd1;
    chk({tag, " rd0 ce"}, 32'(bus.ram_ce), 32'd1);
    chk({tag, " rd0 addr"}, 32'(bus.ram_address), 32'(a0));
    @(negedge clk);
    chk({tag, " rd1 ce"}, 32'(bus.ram_ce), 32'd1);
    chk({tag, " rd1 addr"}, 32'(bus.ram_address), 32'(a1));
    @(negedge clk);
    chk({tag, " land ce"}, 32'(bus.ram_ce), 32'd0);
    chk({tag, " early valid"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, " out_p0"}, 32'(bus.out_p0), 32'(p0));
    chk({tag, " out_p1"}, 32'(bus.out_p1), 32'(p1));
    chk({tag, " out_clamped"}, 32'(bus.out_clamped), 32'(cl));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  b;
    logic [23:0] prev_p1;

    for (int i = 0; i < 4096; i++) mem[i] = 24'(i * 32'h010101);

    vt[0] = '{12'd720,  12'd5,    12'd5,    12'd6,    24'h050505, 24'h060606, 1'b0};
    vt[1] = '{12'd720,  12'd719,  12'd719,  12'd719,  24'hD1D1CF, 24'hD1D1CF, 1'b1};
    vt[2] = '{12'd720,  12'd1000, 12'd719,  12'd719,  24'hD1D1CF, 24'hD1D1CF, 1'b1};
    vt[3] = '{12'd3840, 12'd4095, 12'd3839, 12'd3839, 24'h0E0DFF, 24'h0E0DFF, 1'b1};
    vt[4] = '{12'd0,    12'd7,    12'd0,    12'd0,    24'h000000, 24'h000000, 1'b1};
    vt[5] = '{12'd4,    12'd2,    12'd2,    12'd3,    24'h020202, 24'h030303, 1'b0};
    vt[6] = '{12'd4,    12'd3,    12'd3,    12'd3,    24'h030303, 24'h030303, 1'b1};
    vt[7] = '{12'd4000, 12'd3838, 12'd3838, 12'd3839, 24'h0D0CFE, 24'h0E0DFF, 1'b0};
    vt[8] = '{12'd720,  12'd718,  12'd718,  12'd719,  24'hD0D0CE, 24'hD1D1CF, 1'b0};

    bus.req_valid = 1'b0;
    bus.req_col   = '0;
    bus.cfg_width = 12'd720;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset ram_ce", 32'(bus.ram_ce), 32'd0);
    chk("reset ram_address", 32'(bus.ram_address), 32'd0);
    chk("reset out_p0", 32'(bus.out_p0), 32'd0);
    chk("reset out_p1", 32'(bus.out_p1), 32'd0);
    chk("reset out_clamped", 32'(bus.out_clamped), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 9; i++)
      run_req($sformatf("vec%0d", i), vt[i].width, vt[i].col, vt[i].a0, vt[i].a1,
              vt[i].p0, vt[i].p1, vt[i].cl);

    // Back-to-back columns 0..15, one pair every 4 cycles.
    prev_p1 = '0;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i);
      run_req($sformatf("b2b%0d", i), 12'd720, 12'(i), 12'(i), 12'(i + 1),
              {b, b, b}, {b + 8'd1, b + 8'd1, b + 8'd1}, 1'b0);
      if (i > 0) chk($sformatf("b2b%0d chain", i), 32'(bus.out_p0), 32'(prev_p1));
      prev_p1 = bus.out_p1;
    end

    // Stall: first pair held while the second lands, then drain and load without a bubble.
    @(negedge clk);
    chk("drained valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    run_req("stallA", 12'd720, 12'd20, 12'd20, 12'd21, 24'h141414, 24'h151515, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_col   = 12'd30;
    bus.cfg_width = 12'd720;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("stall valid", 32'(bus.out_valid), 32'd1);
    chk("stall held p0", 32'(bus.out_p0), 32'h141414);
    chk("stall held p1", 32'(bus.out_p1), 32'h151515);
    chk("stall req_ready", 32'(bus.req_ready), 32'd0);
    chk("stall busy", 32'(bus.busy), 32'd1);
    chk("stall ram_ce", 32'(bus.ram_ce), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release valid", 32'(bus.out_valid), 32'd1);
    chk("release p0", 32'(bus.out_p0), 32'h1E1E1E);
    chk("release p1", 32'(bus.out_p1), 32'h1F1F1F);
    chk("release req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    chk("release drained", 32'(bus.out_valid), 32'd0);

    // Reset while the second read is in flight.
    bus.req_valid = 1'b1;
    bus.req_col   = 12'd40;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst-rd1 addr", 32'(bus.ram_address), 32'd41);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst-rd1 ram_ce", 32'(bus.ram_ce), 32'd0);
    chk("rst-rd1 out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst-rd1 req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst-rd1 busy", 32'(bus.busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("rst-rd1 quiet", 32'(bus.out_valid), 32'd0);
    run_req("after-rst", 12'd720, 12'd10, 12'd10, 12'd11, 24'h0A0A0A, 24'h0B0B0B, 1'b0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
